// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial front end: takes an operand pair over valid/ready and
// streams both words LSB-first with first/last bit markers for a serial adder.
module serial_operand_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_a,
   input  logic [WIDTH-1:0] up_b,
   output logic             up_ready,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_first,
   output logic             ser_last
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             first_reg;
   logic             last_reg;
   logic             beat;
   logic             up_accept;
   logic [CW-1:0]    cnt_next;

   // A new pair may enter in IDLE, or on the final beat so words run back-to-back.
   always_comb begin
      up_ready = 1'b0;
      if (!rst) begin
         case (state_reg)
            IDLE:    up_ready = 1'b1;
            SHIFT:   up_ready = last_reg & ser_ready;
            default: up_ready = 1'b0;
         endcase
      end
   end

   assign beat      = (state_reg == SHIFT) & ser_ready;
   assign up_accept = up_valid & up_ready;
   assign cnt_next  = cnt_reg + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         first_reg <= 1'b0;
         last_reg  <= 1'b0;
      end else if (up_accept) begin
         state_reg <= SHIFT;
         cnt_reg   <= '0;
         a_reg     <= up_a;
         b_reg     <= up_b;
         first_reg <= 1'b1;
         last_reg  <= (WIDTH == 1);
      end else if (beat) begin
         if (last_reg) begin
            // Word done with no follow-on pair: clear so idle outputs read 0.
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
         end else begin
            cnt_reg   <= cnt_next;
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            first_reg <= 1'b0;
            last_reg  <= (cnt_next == LAST_CNT);
         end
      end
   end

   assign ser_valid = (state_reg == SHIFT);
   assign ser_a     = a_reg[0];
   assign ser_b     = b_reg[0];
   assign ser_first = first_reg;
   assign ser_last  = last_reg;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: word-level reference model, per-cycle
// output compare, serial-adder sum collector and directed literal checks.
module tb_serial_operand_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       up_valid;
   logic [7:0] up_a, up_b;
   logic       up_ready, ser_valid, ser_ready, ser_a, ser_b, ser_first, ser_last;

   logic u1_valid, u1_a, u1_b, u1_ready, s1_valid, s1_ready, s1_a, s1_b, s1_first, s1_last;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   serial_operand_serializer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_a(up_a), .up_b(up_b),
      .up_ready(up_ready), .ser_valid(ser_valid), .ser_ready(ser_ready),
      .ser_a(ser_a), .ser_b(ser_b), .ser_first(ser_first), .ser_last(ser_last)
   );

   serial_operand_serializer #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .up_valid(u1_valid), .up_a(u1_a), .up_b(u1_b),
      .up_ready(u1_ready), .ser_valid(s1_valid), .ser_ready(s1_ready),
      .ser_a(s1_a), .ser_b(s1_b), .ser_first(s1_first), .ser_last(s1_last)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the word in flight and which of its bits is on the outputs.
   bit         started = 0;
   bit         busy = 0;
   logic [7:0] ca = '0, cb = '0;
   int         idx = 0;

   always @(posedge clk) begin
      if (rst) begin
         started = 1;
         busy    = 0;
      end else if (busy) begin
         if (ser_ready) begin
            if (idx == 7) begin
               if (up_valid) begin
                  ca = up_a; cb = up_b; idx = 0;
               end else begin
                  busy = 0;
               end
            end else begin
               idx++;
            end
         end
      end else if (up_valid) begin
         busy = 1; ca = up_a; cb = up_b; idx = 0;
      end
   end

   // Compare process plus a serial adder that rebuilds words from the stream.
   int         cyc_n = 0;
   int         pos = 0;
   logic       carry = 0;
   logic [7:0] acc_a = '0, acc_b = '0, acc_s = '0;
   logic [7:0] col_a[$], col_b[$], col_s[$];
   int         firsts[$];

   always @(negedge clk) begin
      if (started) begin
         logic [5:0] exp_v, act_v;
         logic [8:0] sm;
         cyc_n++;
         exp_v[5] = rst ? 1'b0 : (busy ? (idx == 7 && ser_ready) : 1'b1);
         exp_v[4] = busy;
         exp_v[3] = busy & ca[idx];
         exp_v[2] = busy & cb[idx];
         exp_v[1] = busy && idx == 0;
         exp_v[0] = busy && idx == 7;
         act_v = {up_ready, ser_valid, ser_a, ser_b, ser_first, ser_last};
         check("cycle", 32'(act_v), 32'(exp_v));
         if (ser_valid === 1'b1 && ser_ready) begin
            if (ser_first) begin
               pos = 0; carry = 0; acc_a = '0; acc_b = '0; acc_s = '0;
               firsts.push_back(cyc_n);
            end
            if (pos < 8) begin
               acc_a[pos] = ser_a;
               acc_b[pos] = ser_b;
               acc_s[pos] = ser_a ^ ser_b ^ carry;
               carry = (ser_a & ser_b) | (carry & (ser_a ^ ser_b));
               pos++;
            end
            if (ser_last) begin
               sm = {1'b0, ca} + {1'b0, cb};
               check("sum", 32'(acc_s), 32'(sm[7:0]));
               col_a.push_back(acc_a);
               col_b.push_back(acc_b);
               col_s.push_back(acc_s);
            end
         end
      end
   end

   initial begin
      logic [1:0] p1[3];
      int n, m;
      p1[0] = 2'b11; p1[1] = 2'b01; p1[2] = 2'b10;
      rst = 1; up_valid = 0; up_a = '0; up_b = '0; ser_ready = 1;
      u1_valid = 0; u1_a = 0; u1_b = 0; s1_ready = 1;
      repeat (3) cyc();
      rst = 0;
      @(negedge clk);
      check("reset_idle", 32'({up_ready, ser_valid, ser_a, ser_b, ser_first, ser_last}), 32'h20);
      check("w1_reset_idle", 32'({u1_ready, s1_valid, s1_first, s1_last}), 32'h8);
      cyc();

      // Single word A5/3C
      n = col_a.size();
      up_valid = 1; up_a = 8'hA5; up_b = 8'h3C;
      cyc();
      up_valid = 0; up_a = 8'h00; up_b = 8'hFF;
      repeat (10) cyc();
      check("t1_words", col_a.size() - n, 1);
      if (col_a.size() > n) begin
         check("t1_a", 32'(col_a[n]), 32'hA5);
         check("t1_b", 32'(col_b[n]), 32'h3C);
         check("t1_sum", 32'(col_s[n]), 32'hE1);
      end

      // Back-to-back words
      n = col_a.size(); m = firsts.size();
      up_valid = 1; up_a = 8'hFF; up_b = 8'h01;
      cyc();
      up_a = 8'h00; up_b = 8'h80;
      repeat (8) cyc();
      up_valid = 0;
      repeat (10) cyc();
      check("t2_words", col_a.size() - n, 2);
      if (col_s.size() > n + 1 && firsts.size() > m + 1) begin
         check("t2_sum0", 32'(col_s[n]), 32'h00);
         check("t2_sum1", 32'(col_s[n+1]), 32'h80);
         check("t2_gap", firsts[m+1] - firsts[m], 8);
      end

      // Stalls on beats 3 and 4
      n = col_a.size();
      up_valid = 1; up_a = 8'h96; up_b = 8'h69;
      cyc();
      up_valid = 0; up_a = 8'h00;
      cyc(); cyc();
      ser_ready = 0; cyc(); cyc(); ser_ready = 1;
      cyc();
      ser_ready = 0; cyc(); cyc(); ser_ready = 1;
      repeat (8) cyc();
      check("t3_words", col_a.size() - n, 1);
      if (col_a.size() > n) check("t3_a", 32'(col_a[n]), 32'h96);

      // Reset on beat 5
      n = col_a.size();
      up_valid = 1; up_a = 8'h5A; up_b = 8'hC3;
      cyc();
      up_valid = 0;
      repeat (4) cyc();
      rst = 1; cyc(); rst = 0;
      @(negedge clk);
      check("t4_after_rst", 32'({ser_valid, up_ready}), 32'h1);
      cyc();
      up_valid = 1; up_a = 8'h01; up_b = 8'h00;
      cyc();
      up_valid = 0;
      @(negedge clk);
      check("t4_first_bit", 32'({ser_valid, ser_first, ser_a}), 32'h7);
      repeat (10) cyc();
      check("t4_words", col_a.size() - n, 1);
      if (col_a.size() > n) check("t4_a", 32'(col_a[n]), 32'h01);

      // WIDTH=1 instance streaming three pairs
      {u1_a, u1_b} = p1[0]; u1_valid = 1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (k < 2) {u1_a, u1_b} = p1[k+1];
         else u1_valid = 0;
         @(negedge clk);
         check("w1_beat", 32'({s1_valid, s1_first, s1_last, s1_a, s1_b}), 32'({3'b111, p1[k]}));
      end
      cyc();
      @(negedge clk);
      check("w1_idle", 32'({s1_valid, u1_ready}), 32'h1);
      cyc();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         up_valid  = ($urandom % 2) == 0;
         up_a      = 8'($urandom);
         up_b      = 8'($urandom);
         ser_ready = ($urandom % 4) != 0;
         rst       = ($urandom % 150) == 0;
         cyc();
      end
      rst = 0; up_valid = 0; ser_ready = 1;
      repeat (12) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
